conv_stream_engine: RTL and testbench

Parametrised, sequential linear-convolution engine, the successor to the fixed 8×8, 4-bit combinational convolver. It loads an NX-sample sequence x and an NH-sample kernel h over a valid/ready input stream. It then computes all NX+NH-1 full-precision outputs with a single shared multiply-accumulate (MAC) unit and streams them out over a valid/ready output port. It sits between a sample source (FIFO/DMA) and downstream filtering stages, trading throughput for area.

---
 rtl/conv_stream_if.sv | 24 ++
 rtl/conv_stream_engine.sv | 135 +++++++++++++
 tb/tb_conv_stream_engine.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_stream_if.sv
// Stream bundle for conv_stream_engine: sample input port and y output port.
// slave  = engine side, master = source/sink side.
interface conv_stream_if #(
  parameter int DW = 4,
  parameter int OW = 11
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_stream_engine.sv
// conv_stream_engine: loads x[0..NX-1] then h[0..NH-1], computes the full
// linear convolution y[0..NX+NH-2] with one shared MAC (one product per
// clock) and streams each y out over a valid/ready port.
// Optional build macro: CONV_SIGNED_EN (two's complement operands,
// sign-extended products); otherwise operands are unsigned.
module conv_stream_engine #(
  parameter int DW = 4,
  parameter int NX = 8,
  parameter int NH = 8,
  parameter int OW = 2*DW + $clog2((NX < NH) ? NX : NH)
) (
  input  logic         clk,
  input  logic         rst_n,
  conv_stream_if.slave s,
  output logic         busy
);
  localparam int NT = NX + NH;           // total loaded samples
  localparam int NW = $clog2(NT);        // width of every index/counter
  localparam int PW = (OW > 2*DW) ? OW : 2*DW;

  localparam logic [NW-1:0] LAST_LD = NW'(NT-1);
  localparam logic [NW-1:0] LAST_N  = NW'(NT-2);
  localparam logic [NW-1:0] HBASE   = NW'(NX);
  localparam logic [NW-1:0] NXM1    = NW'(NX-1);
  localparam logic [NW-1:0] NHM1    = NW'(NH-1);
  localparam logic [NW-1:0] ONE     = NW'(1);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

  state_t        state, nstate;
  // x lives in slots 0..NX-1, h in slots NX..NX+NH-1, so the load counter
  // doubles as the write address.
  logic [DW-1:0] sbuf [NT];
  logic [NW-1:0] lcnt, n, k;
  logic [OW-1:0] acc;

  logic [DW-1:0] xk, hk;
  logic [PW-1:0] xe, he, prod;
  logic          in_fire, out_fire, k_last, n_last, ld_last;

  // first tap of y[nn]: max(0, nn-NH+1)
  function automatic logic [NW-1:0] kmin(input logic [NW-1:0] nn);
    return (nn > NHM1) ? (nn - NHM1) : '0;
  endfunction

  // last tap of y[nn]: min(nn, NX-1)
  function automatic logic [NW-1:0] kmax(input logic [NW-1:0] nn);
    return (nn < NXM1) ? nn : NXM1;
  endfunction

  assign in_fire  = (state == S_LOAD) && s.in_valid;
  assign out_fire = (state == S_OUTPUT) && s.out_ready;
  assign k_last   = (k == kmax(n));
  assign n_last   = (n == LAST_N);
  assign ld_last  = (lcnt == LAST_LD);

  // MAC operands: x[k] and h[n-k]. Operands are extended to PW before the
  // multiply so the low OW bits equal the 2*DW-bit product extended to OW.
  assign xk = sbuf[k];
  assign hk = sbuf[HBASE + n - k];
`ifdef CONV_SIGNED_EN
  assign xe = {{(PW-DW){xk[DW-1]}}, xk};
  assign he = {{(PW-DW){hk[DW-1]}}, hk};
`else
  assign xe = {{(PW-DW){1'b0}}, xk};
  assign he = {{(PW-DW){1'b0}}, hk};
`endif
  assign prod = xe * he;

  assign s.in_ready  = (state == S_LOAD);
  assign s.out_valid = (state == S_OUTPUT);
  assign s.out_data  = acc;
  assign s.out_last  = (state == S_OUTPUT) && n_last;
  assign busy        = (state != S_LOAD);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= nstate;
  end

  // next-state: LOAD until last h sample, COMPUTE for L(n) clocks, OUTPUT
  // until accepted, then next y or back to LOAD after the last one
  always_comb begin
    nstate = state;
    case (state)
      S_LOAD:    if (in_fire && ld_last) nstate = S_COMPUTE;
      S_COMPUTE: if (k_last)             nstate = S_OUTPUT;
      S_OUTPUT:  if (s.out_ready)        nstate = n_last ? S_LOAD : S_COMPUTE;
      default:                           nstate = S_LOAD;
    endcase
  end

  // sample buffer: contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (in_fire) sbuf[lcnt] <= s.in_data;
  end

  // counters and accumulator; all hold while OUTPUT is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt <= '0;
      n    <= '0;
      k    <= '0;
      acc  <= '0;
    end else begin
      case (state)
        S_LOAD: if (in_fire) begin
          if (ld_last) begin
            lcnt <= '0;
            n    <= '0;
            k    <= '0;
            acc  <= '0;
          end else begin
            lcnt <= lcnt + ONE;
          end
        end
        S_COMPUTE: begin
          acc <= acc + prod[OW-1:0];
          k   <= k + ONE;
        end
        S_OUTPUT: if (out_fire) begin
          if (n_last) begin
            lcnt <= '0;
          end else begin
            n   <= n + ONE;
            k   <= kmin(n + ONE);
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_stream_engine.sv
// Bench for conv_stream_engine: directed jobs (ramp, impulse, max, sign),
// back-pressure, random jobs with input gaps and random out_ready, and an
// asynchronous reset mid-COMPUTE. Expected y comes from a direct
// double-sum convolution of the loaded x/h arrays.
module tb_conv_stream_engine;
  localparam int DW = 4;
  localparam int NX = 8;
  localparam int NH = 8;
  localparam int OW = 11;
  localparam int NY = NX + NH - 1;
  localparam int FULL_CYC = NX*NH + NY;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  always #5 clk = ~clk;

  conv_stream_if #(.DW(DW), .OW(OW)) bus ();

  conv_stream_engine #(.DW(DW), .NX(NX), .NH(NH), .OW(OW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s    (bus.slave),
    .busy (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int xs [NX];
  int hs [NH];
  logic [OW-1:0] yexp [NY];
  logic [OW-1:0] got  [NY];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sval(input int v);
`ifdef CONV_SIGNED_EN
    return (v >= (1 << (DW-1))) ? v - (1 << DW) : v;
`else
    return v;
`endif
  endfunction

  // reference: y[n] = sum over all valid k of x[k]*h[n-k], wrapped to OW bits
  task automatic model();
    for (int nn = 0; nn < NY; nn++) begin
      int sum;
      logic [31:0] t;
      sum = 0;
      for (int kk = 0; kk < NX; kk++)
        if (nn - kk >= 0 && nn - kk < NH) sum += sval(xs[kk]) * sval(hs[nn-kk]);
      t = sum;
      yexp[nn] = t[OW-1:0];
    end
  endtask

  task automatic do_load(input bit gaps);
    for (int i = 0; i < NX + NH; i++) begin
      if (gaps)
        while ($urandom_range(0, 2) == 0) begin
          bus.in_valid = 1'b0;
          bus.in_data  = DW'($urandom);
          @(negedge clk);
        end
      bus.in_valid = 1'b1;
      bus.in_data  = DW'((i < NX) ? xs[i] : hs[i-NX]);
      chk("in_ready_load", bus.in_ready, 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  // Collect outputs. stall_at/stall_len force out_ready low on one sample;
  // exp_cyc>0 checks the final handshake cycle; abort_at>=0 returns at the
  // first COMPUTE cycle of y[abort_at].
  task automatic do_out(input bit rnd_bp, input int stall_at, input int stall_len,
                        input int exp_cyc, input int abort_at);
    int idx, cyc, stalled;
    bit prev_hs, rdy;
    idx = 0; cyc = 0; stalled = 0; prev_hs = 0;
    chk("busy_compute", busy, 1);
    chk("in_ready_compute", bus.in_ready, 0);
    while (idx < NY) begin
      cyc++;
      if (cyc > 5000) begin
        chk("timeout_idx", idx, NY);
        break;
      end
      if (prev_hs) chk("valid_gap", bus.out_valid, 0);
      prev_hs = 0;
      rdy = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid) begin
        if (idx == stall_at && stalled < stall_len) begin
          rdy = 1'b0;
          stalled++;
        end
        chk("y", bus.out_data, yexp[idx]);
        chk("last", bus.out_last, idx == NY-1);
        got[idx] = bus.out_data;
        if (rdy) begin
          if (idx == NY-1 && exp_cyc > 0) chk("job_cycles", cyc, exp_cyc);
          idx++;
          prev_hs = 1;
        end
      end
      bus.out_ready = rdy;
      @(negedge clk);
      if (idx == abort_at) return;
    end
    bus.out_ready = 1'b0;
    chk("in_ready_after", bus.in_ready, 1);
    chk("busy_after", busy, 0);
    chk("out_valid_after", bus.out_valid, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int imp [NX];
    imp = '{3, 1, 4, 1, 5, 9, 2, 6};
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // ramp x=1..8, h=1: exact latency
    for (int i = 0; i < NX; i++) xs[i] = i + 1;
    for (int i = 0; i < NH; i++) hs[i] = 1;
    model();
    do_load(1'b0);
    do_out(1'b0, -1, 0, FULL_CYC, -1);
    chk("ramp_y0", got[0], 1);
    chk("ramp_y7", got[7], 36);
    chk("ramp_y14", got[14], 8);

    // impulse
    for (int i = 0; i < NX; i++) xs[i] = imp[i];
    for (int i = 0; i < NH; i++) hs[i] = (i == 0) ? 1 : 0;
    model();
    do_load(1'b1);
    do_out(1'b0, -1, 0, FULL_CYC, -1);
    chk("imp_y5", got[5], 9);
    chk("imp_y14", got[14], 0);

    // max magnitude
    for (int i = 0; i < NX; i++) xs[i] = 15;
    for (int i = 0; i < NH; i++) hs[i] = 15;
    model();
    do_load(1'b0);
    do_out(1'b0, -1, 0, FULL_CYC, -1);
`ifndef CONV_SIGNED_EN
    chk("max_y7", got[7], 11'h708);
`endif

    // x=-1 (signed) / 15 (unsigned), h=1
    for (int i = 0; i < NH; i++) hs[i] = 1;
    model();
    do_load(1'b0);
    do_out(1'b0, -1, 0, FULL_CYC, -1);
`ifdef CONV_SIGNED_EN
    chk("sign_y7", got[7], 11'h7F8);
`else
    chk("sign_y7", got[7], 120);
`endif

    // back-pressure on y[3] for 5 cycles
    for (int i = 0; i < NX; i++) xs[i] = i + 1;
    model();
    do_load(1'b1);
    do_out(1'b0, 3, 5, 0, -1);
    chk("bp_y3", got[3], 10);
    chk("bp_y4", got[4], 15);

    // random jobs with input gaps and random out_ready
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < NX; i++) xs[i] = $urandom_range(0, 15);
      for (int i = 0; i < NH; i++) hs[i] = $urandom_range(0, 15);
      model();
      do_load(1'b1);
      do_out(1'b1, -1, 0, 0, -1);
    end

    // reset mid-COMPUTE at n=5, then a fresh full job
    for (int i = 0; i < NX; i++) xs[i] = $urandom_range(0, 15);
    for (int i = 0; i < NH; i++) hs[i] = $urandom_range(0, 15);
    model();
    do_load(1'b0);
    do_out(1'b0, -1, 0, 0, 5);
    chk("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NX; i++) xs[i] = $urandom_range(0, 15);
    for (int i = 0; i < NH; i++) hs[i] = $urandom_range(0, 15);
    model();
    do_load(1'b1);
    do_out(1'b0, -1, 0, FULL_CYC, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
